// File: rtl/dc_ipu_shr_pipeline_ctrl_pkg.sv
// Shared types and defaults for the IPU skid-buffered pipeline controller.
package dc_ipu_shr_pipe_pkg;

    localparam int NUM_STAGES_DEF = 2;
    localparam int CNT_W_DEF      = 32;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } stage_st_t;

endpackage

// File: rtl/dc_ipu_shr_pipeline_ctrl_if.sv
// Handshake and strobe bundle of the pipeline controller.
// master = producer/consumer/datapath side, slave = the controller.
interface dc_ipu_shr_pipeline_ctrl_if #(
    parameter int NUM_STAGES = dc_ipu_shr_pipe_pkg::NUM_STAGES_DEF
);
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [NUM_STAGES-1:0] buf_main_en;
    logic [NUM_STAGES-1:0] buf_side_en;
    logic [NUM_STAGES-1:0] buf_restore;
    logic [NUM_STAGES-1:0] stage_valid;
    logic                  busy;

    modport master (
        output flush, in_valid, out_ready,
        input  in_ready, out_valid, buf_main_en, buf_side_en, buf_restore,
               stage_valid, busy
    );

    modport slave (
        input  flush, in_valid, out_ready,
        output in_ready, out_valid, buf_main_en, buf_side_en, buf_restore,
               stage_valid, busy
    );
endinterface

// File: rtl/dc_ipu_shr_pipeline_ctrl_stage.sv
// One skid-buffer stage controller: EMPTY/BUSY/FULL state, ready/valid decode
// from registered state only, main/side/restore strobes for the datapath.
module dc_ipu_shr_pipeline_stage_ctrl
    import dc_ipu_shr_pipe_pkg::*;
(
    input  logic clk,
    input  logic nreset,
    input  logic flush,
    input  logic s_valid,
    output logic s_ready,
    output logic d_valid,
    input  logic d_ready,
    output logic main_en,
    output logic side_en,
    output logic restore
);

    stage_st_t st, st_nxt;

    assign s_ready = (st != ST_FULL);
    assign d_valid = (st != ST_EMPTY);

    // Strobes are masked while nreset is low so the datapath never loads in reset.
    always_comb begin
        st_nxt  = st;
        main_en = 1'b0;
        side_en = 1'b0;
        restore = 1'b0;
        if (flush) begin
            st_nxt = ST_EMPTY;
        end else if (nreset) begin
            case (st)
                ST_EMPTY: begin
                    if (s_valid) begin
                        main_en = 1'b1;
                        st_nxt  = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (s_valid && d_ready) begin
                        main_en = 1'b1;
                    end else if (s_valid) begin
                        side_en = 1'b1;
                        st_nxt  = ST_FULL;
                    end else if (d_ready) begin
                        st_nxt  = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (d_ready) begin
                        main_en = 1'b1;
                        restore = 1'b1;
                        st_nxt  = ST_BUSY;
                    end
                end
                default: st_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) st <= ST_EMPTY;
        else         st <= st_nxt;
    end

endmodule

// File: rtl/dc_ipu_shr_pipeline_ctrl.sv
// Valid/ready controller for a chain of NUM_STAGES skid-buffered stages.
// Optional DC_IPU_SHR_PIPE_PERF_EN adds xfer_cnt/stall_cnt output counters.
module dc_ipu_shr_pipeline_ctrl
    import dc_ipu_shr_pipe_pkg::*;
#(
    parameter int NUM_STAGES = NUM_STAGES_DEF
`ifdef DC_IPU_SHR_PIPE_PERF_EN
   ,parameter int CNT_W      = CNT_W_DEF
`endif
)(
    input  logic                    clk,
    input  logic                    nreset,
    dc_ipu_shr_pipeline_ctrl_if.slave bus
`ifdef DC_IPU_SHR_PIPE_PERF_EN
   ,output logic [CNT_W-1:0]        xfer_cnt,
    output logic [CNT_W-1:0]        stall_cnt
`endif
);

    // Index i is the boundary feeding stage i; index NUM_STAGES is the output port.
    logic [NUM_STAGES:0]   v_chain;
    logic [NUM_STAGES:0]   r_chain;
    logic [NUM_STAGES-1:0] main_en;
    logic [NUM_STAGES-1:0] side_en;
    logic [NUM_STAGES-1:0] restore;

    assign v_chain[0]          = bus.in_valid;
    assign r_chain[NUM_STAGES] = bus.out_ready;

    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
        dc_ipu_shr_pipeline_stage_ctrl u_stage (
            .clk     (clk),
            .nreset  (nreset),
            .flush   (bus.flush),
            .s_valid (v_chain[i]),
            .s_ready (r_chain[i]),
            .d_valid (v_chain[i+1]),
            .d_ready (r_chain[i+1]),
            .main_en (main_en[i]),
            .side_en (side_en[i]),
            .restore (restore[i])
        );
    end

    assign bus.in_ready    = r_chain[0];
    assign bus.out_valid   = v_chain[NUM_STAGES];
    assign bus.buf_main_en = main_en;
    assign bus.buf_side_en = side_en;
    assign bus.buf_restore = restore;
    assign bus.stage_valid = v_chain[NUM_STAGES:1];
    assign bus.busy        = |v_chain[NUM_STAGES:1];

`ifdef DC_IPU_SHR_PIPE_PERF_EN
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            xfer_cnt  <= '0;
            stall_cnt <= '0;
        end else if (bus.flush) begin
            xfer_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (bus.out_valid && bus.out_ready)  xfer_cnt  <= xfer_cnt + 1'b1;
            if (bus.out_valid && !bus.out_ready) stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dc_ipu_shr_pipeline_ctrl.sv
// Scoreboard bench: a token datapath driven by the strobes carries sequence
// numbers; the output monitor checks order and strobe legality every cycle.
module tb_dc_ipu_shr_pipeline_ctrl;

    localparam int NS = 2;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    dc_ipu_shr_pipeline_ctrl_if #(.NUM_STAGES(NS)) ifc();

`ifdef DC_IPU_SHR_PIPE_PERF_EN
    logic [31:0] xfer_cnt, stall_cnt;
`endif

    dc_ipu_shr_pipeline_ctrl #(.NUM_STAGES(NS)) dut (
        .clk       (clk),
        .nreset    (nreset),
        .bus       (ifc)
`ifdef DC_IPU_SHR_PIPE_PERF_EN
       ,.xfer_cnt  (xfer_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;
    int acc_cnt = 0;
    int n_out  = 0;
    logic [NS-1:0] restore_seen = '0;
    logic [15:0]   exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Token datapath: stage 0 loads the next sequence number, stage i loads stage i-1.
    logic [15:0] tok;
    logic [15:0] dmain [NS];
    logic [15:0] dside [NS];

    always @(posedge clk or negedge nreset) begin
        if (!nreset) tok <= '0;
        else if (ifc.in_valid && ifc.in_ready && !ifc.flush) tok <= tok + 16'd1;
    end

    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            if (ifc.buf_main_en[i])
                dmain[i] <= ifc.buf_restore[i] ? dside[i] : ((i == 0) ? tok : dmain[(i == 0) ? 0 : i-1]);
            if (ifc.buf_side_en[i])
                dside[i] <= (i == 0) ? tok : dmain[(i == 0) ? 0 : i-1];
        end
    end

    // Input side: every accepted word is pushed as the expected next output.
    always @(negedge clk) begin
        if (!nreset || ifc.flush) begin
            exp_q.delete();
        end else if (ifc.in_valid && ifc.in_ready) begin
            exp_q.push_back(tok);
            acc_cnt++;
        end
    end

    // Output monitor.
    always @(negedge clk) begin
        if (nreset) begin
            check("strobe_excl", 32'(ifc.buf_main_en & ifc.buf_side_en), 32'd0);
            check("restore_qual", 32'(ifc.buf_restore & ~ifc.buf_main_en), 32'd0);
            restore_seen = restore_seen | ifc.buf_restore;
            if (ifc.out_valid && ifc.out_ready && !ifc.flush) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    check("sb_order", 32'(dmain[NS-1]), 32'(e));
                    n_out++;
                end
            end
        end
    end

    task automatic tick(); @(posedge clk); #1; endtask
    task automatic samp(); @(negedge clk); #1; endtask

    task automatic drain();
        int t;
        t = 0;
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b1;
        tick();
        while (ifc.busy && t < 50) begin
            tick();
            t++;
        end
        check("drain_timeout", 32'(t < 50), 32'd1);
    endtask

    task automatic fill6();
        ifc.out_ready = 1'b0;
        ifc.in_valid  = 1'b1;
        repeat (6) tick();
        ifc.in_valid  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        int base_acc, base_out, c;
        ifc.flush     = 1'b0;
        ifc.in_valid  = 1'b1;
        ifc.out_ready = 1'b1;

        // Reset state, with stimulus active to prove strobes stay quiet.
        repeat (2) @(posedge clk);
        samp();
        check("rst_in_ready",   32'(ifc.in_ready),    32'd1);
        check("rst_out_valid",  32'(ifc.out_valid),   32'd0);
        check("rst_main_en",    32'(ifc.buf_main_en), 32'd0);
        check("rst_side_en",    32'(ifc.buf_side_en), 32'd0);
        check("rst_restore",    32'(ifc.buf_restore), 32'd0);
        check("rst_stage_valid",32'(ifc.stage_valid), 32'd0);
        check("rst_busy",       32'(ifc.busy),        32'd0);

        // Streaming: out_valid rises in cycle 2 and stays, never a side load.
        tick();
        nreset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            samp();
            check("stream_out_valid", 32'(ifc.out_valid), 32'(k >= 2));
            check("stream_no_side",   32'(ifc.buf_side_en), 32'd0);
        end
        tick();
        drain();

        // Fill with out_ready low: 4 of 6 words accepted.
        base_acc = acc_cnt;
        fill6();
        samp();
        check("fill_accepted",    32'(acc_cnt - base_acc), 32'd4);
        check("fill_in_ready",    32'(ifc.in_ready),       32'd0);
        check("fill_stage_valid", 32'(ifc.stage_valid),    32'b11);
        check("fill_busy",        32'(ifc.busy),           32'd1);
        check("fill_out_valid",   32'(ifc.out_valid),      32'd1);

        // Drain the full chain: four words on consecutive cycles, restore in every stage.
        tick();
        restore_seen  = '0;
        base_out      = n_out;
        ifc.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            samp();
            check("unload_out_valid", 32'(ifc.out_valid), 32'd1);
        end
        samp();
        check("unload_busy",    32'(ifc.busy),          32'd0);
        check("unload_restore", 32'(restore_seen),      32'b11);
        check("unload_count",   32'(n_out - base_out),  32'd4);

        // Random in_valid against out_ready 1010 for 1000 words.
        tick();
        base_acc = acc_cnt;
        base_out = n_out;
        c = 0;
        while ((acc_cnt - base_acc) < 1000 && c < 20000) begin
            ifc.out_ready = ~c[0];
            ifc.in_valid  = ($urandom_range(1) == 1);
            tick();
            c++;
        end
        drain();
        check("rand_accepted", 32'(acc_cnt - base_acc), 32'd1000);
        check("rand_delivered",32'(n_out - base_out),   32'd1000);
        check("rand_q_empty",  32'(exp_q.size()),       32'd0);

        // Flush a full chain with in_valid high.
        fill6();
        ifc.flush    = 1'b1;
        ifc.in_valid = 1'b1;
        samp();
        check("flush_main_en", 32'(ifc.buf_main_en), 32'd0);
        check("flush_side_en", 32'(ifc.buf_side_en), 32'd0);
        check("flush_restore", 32'(ifc.buf_restore), 32'd0);
        tick();
        ifc.flush    = 1'b0;
        ifc.in_valid = 1'b0;
        samp();
        check("postflush_stage_valid", 32'(ifc.stage_valid), 32'd0);
        check("postflush_out_valid",   32'(ifc.out_valid),   32'd0);
        check("postflush_in_ready",    32'(ifc.in_ready),    32'd1);
        check("postflush_busy",        32'(ifc.busy),        32'd0);

        // Flush on an empty chain: in_ready still shown, word still dropped.
        tick();
        ifc.flush    = 1'b1;
        ifc.in_valid = 1'b1;
        samp();
        check("flush_empty_in_ready", 32'(ifc.in_ready),    32'd1);
        check("flush_empty_main_en",  32'(ifc.buf_main_en), 32'd0);
        tick();
        ifc.flush    = 1'b0;
        ifc.in_valid = 1'b0;
        samp();
        check("flush_empty_stage_valid", 32'(ifc.stage_valid), 32'd0);

        // Asynchronous reset mid-stream.
        tick();
        ifc.in_valid  = 1'b1;
        ifc.out_ready = 1'b1;
        repeat (3) tick();
        nreset = 1'b0;
        #1;
        check("midrst_stage_valid", 32'(ifc.stage_valid), 32'd0);
        check("midrst_in_ready",    32'(ifc.in_ready),    32'd1);
        check("midrst_main_en",     32'(ifc.buf_main_en), 32'd0);
        check("midrst_out_valid",   32'(ifc.out_valid),   32'd0);
        tick();
        ifc.in_valid = 1'b0;
        tick();
        nreset = 1'b1;
        samp();
        check("postrst_busy", 32'(ifc.busy), 32'd0);

`ifdef DC_IPU_SHR_PIPE_PERF_EN
        // 10 transfers with 3 stall cycles, then flush clears both counters.
        tick();
        ifc.out_ready = 1'b0;
        ifc.flush     = 1'b1;
        tick();
        ifc.flush     = 1'b0;
        samp();
        check("perf_clr_xfer",  xfer_cnt,  32'd0);
        check("perf_clr_stall", stall_cnt, 32'd0);
        tick();
        base_acc = acc_cnt;
        for (int k = 0; k < 30; k++) begin
            ifc.out_ready = (k < 5) || (k >= 8);
            ifc.in_valid  = (acc_cnt - base_acc) < 10;
            tick();
        end
        samp();
        check("perf_busy",  32'(ifc.busy), 32'd0);
        check("perf_xfer",  xfer_cnt,      32'd10);
        check("perf_stall", stall_cnt,     32'd3);
        tick();
        ifc.out_ready = 1'b0;
        ifc.flush     = 1'b1;
        tick();
        ifc.flush     = 1'b0;
        samp();
        check("perf_flush_xfer",  xfer_cnt,  32'd0);
        check("perf_flush_stall", stall_cnt, 32'd0);
`endif

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
